// File: rtl/cpu_bus_rw_seq.sv
// Burst bus read/write sequencer: one core command becomes N single-word bus beats with ack/err handshake.
// Optional bus wait limit enabled by defining CPU_RW_TIMEOUT_EN (abort after TIMEOUT_CYC cycles in BUS).
module cpu_bus_rw_seq #(
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 4,
    parameter int ADDR_STEP   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              err_timeout,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err
);

`ifdef CPU_RW_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, BUS, DONE, ERR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic [WORD_W-1:0] wdata_reg, wdata_next;
    logic [WORD_W-1:0] rdata_reg, rdata_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic              tmo_flag_reg, tmo_flag_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            rd_valid_reg <= 1'b0;
            tmo_cnt_reg  <= '0;
            tmo_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            rd_valid_reg <= rd_valid_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            tmo_flag_reg <= tmo_flag_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        we_next       = we_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        rd_valid_next = 1'b0;
        tmo_cnt_next  = tmo_cnt_reg;
        tmo_flag_next = tmo_flag_reg;
        case (state_reg)
            IDLE: begin
                tmo_flag_next = 1'b0;
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    we_next    = cmd_we;
                    cnt_next   = cmd_len;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Wait counter restarts on every entry into BUS.
                tmo_cnt_next = '0;
                if (!we_reg) begin
                    state_next = BUS;
                end else if (wr_valid) begin
                    wdata_next = wr_data;
                    state_next = BUS;
                end
            end
            BUS: begin
                tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                // Priority: bus_err, then bus_ack, then timeout.
                if (bus_err) begin
                    state_next = ERR;
                end else if (bus_ack) begin
                    if (!we_reg) begin
                        rdata_next    = bus_rdata;
                        rd_valid_next = 1'b1;
                    end
                    if (cnt_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        cnt_next   = cnt_reg - LEN_W'(1);
                        addr_next  = addr_reg + ADDR_W'(ADDR_STEP);
                        state_next = LOAD;
                    end
                end else if (TMO_EN && (tmo_cnt_reg == TMO_LAST)) begin
                    tmo_flag_next = 1'b1;
                    state_next    = ERR;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign wr_ready    = (state_reg == LOAD) && we_reg;
    assign bus_req     = (state_reg == BUS);
    assign bus_we      = (state_reg == BUS) && we_reg;
    assign bus_addr    = addr_reg;
    assign bus_wdata   = wdata_reg;
    assign rd_data     = rdata_reg;
    assign rd_valid    = rd_valid_reg;
    assign done        = (state_reg == DONE) || (state_reg == ERR);
    assign err         = (state_reg == ERR);
    assign err_timeout = (state_reg == ERR) && tmo_flag_reg;

endmodule

// File: tb/tb_cpu_bus_rw_seq.sv
// Directed bench for cpu_bus_rw_seq: scoreboard queues for bus beats, read data and completion pulses.
module tb_cpu_bus_rw_seq;
    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int LEN_W       = 4;
    localparam int ADDR_STEP   = 4;
    localparam int TIMEOUT_CYC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid, wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid, done, err, err_timeout;
    logic              bus_req, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [WORD_W-1:0] bus_wdata, bus_rdata;
    logic              bus_ack, bus_err;

    always #5 clk = ~clk;

    cpu_bus_rw_seq #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .ADDR_STEP(ADDR_STEP), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .err_timeout(err_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic e;
        logic tmo;
    } end_t;

    beat_t       bus_q[$];
    logic [31:0] rd_q[$];
    end_t        done_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops expectations whenever the DUT emits read data or a completion pulse.
    task automatic mon();
        logic [31:0] e;
        end_t        d;
        if (rd_valid) begin
            if (rd_q.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
            else begin
                e = rd_q.pop_front();
                chk("rd_data", rd_data, e);
                $display("rd beat: data=%08h expected=%08h", rd_data, e);
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", done, 1'b0);
            else begin
                d = done_q.pop_front();
                chk("err", err, d.e);
                chk("err_timeout", err_timeout, d.tmo);
                $display("done: err=%0b err_timeout=%0b", err, err_timeout);
            end
        end else begin
            chk("err_without_done", err, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mon();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus_req && n < 50) begin tick(); n++; end
        chk("bus_req_wait", bus_req, 1'b1);
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [3:0] len,
                            input int n_seen, input logic [31:0] wbase,
                            input logic exp_err, input logic exp_tmo);
        int    n = 0;
        beat_t b;
        end_t  d;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        for (int i = 0; i < n_seen; i++) begin
            b.addr  = addr + 32'(i * ADDR_STEP);
            b.we    = we;
            b.wdata = wbase + 32'(i);
            bus_q.push_back(b);
        end
        d.e = exp_err; d.tmo = exp_tmo;
        done_q.push_back(d);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic serve(input logic ack, input logic berr, input logic [31:0] rdata,
                         input logic [31:0] next_wr);
        beat_t b;
        wait_req();
        if (bus_q.size() == 0) chk("beat_unexpected", bus_req, 1'b0);
        else begin
            b = bus_q.pop_front();
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_we", bus_we, b.we);
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
            $display("bus beat: addr=%08h we=%0b wdata=%08h ack=%0b err=%0b",
                     bus_addr, bus_we, bus_wdata, ack, berr);
            if (ack && !berr && !b.we) rd_q.push_back(rdata);
        end
        bus_ack = ack; bus_err = berr; bus_rdata = rdata; wr_data = next_wr;
        tick();
        bus_ack = 1'b0; bus_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single read latency: accept at cycle 0, LOAD 1, BUS 2, rd_valid/done 3, ready 4.
        begin
            end_t d;
            d.e = 1'b0; d.tmo = 1'b0;
            done_q.push_back(d);
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_len = '0;
            tick();
            cmd_valid = 1'b0;
            chk("c1_bus_req", bus_req, 1'b0);
            chk("c1_cmd_ready", cmd_ready, 1'b0);
            tick();
            chk("c2_bus_req", bus_req, 1'b1);
            chk("c2_bus_addr", bus_addr, 32'h100);
            chk("c2_bus_we", bus_we, 1'b0);
            bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
            rd_q.push_back(32'hDEADBEEF);
            tick();
            bus_ack = 1'b0;
            chk("c3_rd_valid", rd_valid, 1'b1);
            chk("c3_done", done, 1'b1);
            tick();
            chk("c4_cmd_ready", cmd_ready, 1'b1);
        end

        // Write burst across the address wrap with wr_valid held.
        wr_valid = 1'b1; wr_data = 32'd1;
        send_cmd(1'b1, 32'hFFFF_FFF8, 4'd3, 4, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) serve(1'b1, 1'b0, 32'h0, 32'(i + 2));
        wr_valid = 1'b0;
        tick();
        chk("wr_beats_left", bus_q.size(), 0);
        chk("wr_done_left", done_q.size(), 0);

        // Read burst aborted by bus_err (with ack) on the second beat.
        send_cmd(1'b0, 32'h200, 4'd2, 2, 32'h0, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 32'hA0A0_A0A0, 32'h0);
        serve(1'b1, 1'b1, 32'hB0B0_B0B0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("e_no_third_req", bus_req, 1'b0);
            tick();
        end
        chk("e_rd_left", rd_q.size(), 0);
        chk("e_done_left", done_q.size(), 0);

        // Write stalled in LOAD for 5 cycles.
        wr_valid = 1'b0;
        send_cmd(1'b1, 32'h500, 4'd0, 1, 32'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_wr_ready", wr_ready, 1'b1);
            chk("stall_bus_req", bus_req, 1'b0);
            tick();
        end
        wr_valid = 1'b1; wr_data = 32'h55;
        serve(1'b1, 1'b0, 32'h0, 32'h55);
        wr_valid = 1'b0;
        tick();
        chk("stall_done_left", done_q.size(), 0);

        // Maximum length: 16 beats, counter must not end early.
        send_cmd(1'b0, 32'h1000, 4'hF, 16, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) serve(1'b1, 1'b0, 32'hC000 + 32'(i), 32'h0);
        tick();
        chk("max_beats_left", bus_q.size(), 0);
        chk("max_done_left", done_q.size(), 0);
        chk("max_rd_left", rd_q.size(), 0);

        // Reset during BUS of a 4-beat read.
        send_cmd(1'b0, 32'h300, 4'd3, 4, 32'h0, 1'b0, 1'b0);
        serve(1'b1, 1'b0, 32'h3131_3131, 32'h0);
        wait_req();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_q.delete();
        done_q.delete();
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_bus_req", bus_req, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_done", done, 1'b0);
        end

`ifdef CPU_RW_TIMEOUT_EN
        send_cmd(1'b0, 32'h400, 4'd0, 0, 32'h0, 1'b1, 1'b1);
        wait_req();
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            chk("tmo_bus_req", bus_req, 1'b1);
            tick();
        end
        chk("tmo_done", done, 1'b1);
        chk("tmo_flag", err_timeout, 1'b1);
`else
        send_cmd(1'b0, 32'h400, 4'd0, 1, 32'h0, 1'b0, 1'b0);
        wait_req();
        for (int i = 0; i < 100; i++) begin
            chk("hold_bus_req", bus_req, 1'b1);
            tick();
        end
        serve(1'b1, 1'b0, 32'h7777_7777, 32'h0);
`endif
        tick();
        chk("end_done_left", done_q.size(), 0);
        chk("end_rd_left", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
